// File: rtl/mem_pkg.sv
// Shared types, default widths and the parity helper for the dual-port word memory.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package mem_pkg;

  // Clear sequencer states: fill the array first, then serve both ports.
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  localparam int MEM_DATA_W    = 16;
  localparam int MEM_ADDR_W    = 16;
  // Widest word the parity helper accepts; callers zero-extend, which leaves parity unchanged.
  localparam int MEM_PAR_MAX_W = 64;

  // XOR-reduce: the bit that makes the total count of ones even, and also the recheck result.
  function automatic logic even_parity(input logic [MEM_PAR_MAX_W-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/mem_clear_seq.sv
// Post-reset fill sequencer: walks every address once, then hands the array to the ports.
// Latency: exactly DEPTH cycles of busy after reset release; busy drops on the edge writing DEPTH-1.
// Backpressure: none; while busy the parent ignores all port requests.
module mem_clear_seq
  import mem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  output logic             busy,
  output logic             clear_we,
  output logic [IDX_W-1:0] clear_addr
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;

  // State and counter registers; any reset restarts the fill from address 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: one word per cycle in CLEAR, leave after the last index is written.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy     = 1'b0;
    clear_we = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        busy     = 1'b1;
        clear_we = 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  assign clear_addr = cnt_q;

endmodule

// File: rtl/dual_port_memory.sv
// Two-port word memory: read-only fetch port plus read/write data port, cleared after reset.
// Latency: 1 cycle on both read ports (registered data + valid pulse); writes land at the request edge.
// Backpressure: none; requests made while busy are silently dropped. Parity option: DUAL_PORT_MEMORY_PARITY_EN.
module dual_port_memory
  import mem_pkg::*;
#(
  parameter int                DATA_W      = MEM_DATA_W,
  parameter int                ADDR_W      = MEM_ADDR_W,
  parameter int                DEPTH       = 256,
  parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_valid,
  input  logic              data_en,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_valid,
  output logic              addr_err,
  output logic              busy,
  output logic              par_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef DUAL_PORT_MEMORY_PARITY_EN
  localparam int WORD_W = DATA_W + 1;
`else
  localparam int WORD_W = DATA_W;
`endif
  // One extra bit so DEPTH == 2**ADDR_W is still representable as the limit.
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

  logic              clear_we;
  logic [IDX_W-1:0]  clear_addr;
  logic              run;
  logic              fetch_in, data_in;
  logic [IDX_W-1:0]  fetch_idx, data_idx;
  logic              fetch_rd, data_rd, data_wr;
  logic [WORD_W-1:0] clear_word, wr_word;
  logic [WORD_W-1:0] fetch_word, data_word;
  logic [WORD_W-1:0] mem [DEPTH];

  mem_clear_seq #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_clear_seq (
    .clk        (clk),
    .rst        (rst),
    .busy       (busy),
    .clear_we   (clear_we),
    .clear_addr (clear_addr)
  );

  assign run       = ~busy;
  assign fetch_in  = ({1'b0, fetch_addr} < DEPTH_LIM);
  assign data_in   = ({1'b0, data_addr} < DEPTH_LIM);
  assign fetch_idx = fetch_addr[IDX_W-1:0];
  assign data_idx  = data_addr[IDX_W-1:0];
  assign fetch_rd  = run & fetch_en;
  assign data_rd   = run & data_en & ~data_we;
  assign data_wr   = run & data_en & data_we & data_in;

`ifdef DUAL_PORT_MEMORY_PARITY_EN
  assign clear_word = {even_parity(MEM_PAR_MAX_W'(CLEAR_VALUE)), CLEAR_VALUE};
  assign wr_word    = {even_parity(MEM_PAR_MAX_W'(data_wdata)), data_wdata};
`else
  assign clear_word = CLEAR_VALUE;
  assign wr_word    = data_wdata;
`endif

  // Raw array reads; both ports sample before this edge's write lands, so a colliding fetch sees the old word.
  assign fetch_word = mem[fetch_idx];
  assign data_word  = mem[data_idx];

  // Single write port: the clear sequencer owns it while busy, the data port afterwards.
  always_ff @(posedge clk) begin
    if (clear_we) begin
      mem[clear_addr] <= clear_word;
    end else if (data_wr) begin
      mem[data_idx] <= wr_word;
    end
  end

  // Read registers and status pulses; data outputs hold when no read completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_data  <= '0;
      data_rdata  <= '0;
      fetch_valid <= 1'b0;
      data_valid  <= 1'b0;
      addr_err    <= 1'b0;
    end else begin
      fetch_valid <= fetch_rd;
      data_valid  <= data_rd;
      addr_err    <= (fetch_rd & ~fetch_in) | (run & data_en & ~data_in);
      if (fetch_rd) begin
        fetch_data <= fetch_in ? fetch_word[DATA_W-1:0] : '0;
      end
      if (data_rd) begin
        data_rdata <= data_in ? data_word[DATA_W-1:0] : '0;
      end
    end
  end

`ifdef DUAL_PORT_MEMORY_PARITY_EN
  // Parity recheck on in-range reads of either port, flagged alongside the valid pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_err <= 1'b0;
    end else begin
      par_err <= (fetch_rd & fetch_in & even_parity(MEM_PAR_MAX_W'(fetch_word)))
               | (data_rd  & data_in  & even_parity(MEM_PAR_MAX_W'(data_word)));
    end
  end
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_dual_port_memory.sv
module tb_dual_port_memory;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic [15:0] fetch_addr;
  logic [15:0] fetch_data;
  logic        fetch_valid;
  logic        data_en;
  logic        data_we;
  logic [15:0] data_addr;
  logic [15:0] data_wdata;
  logic [15:0] data_rdata;
  logic        data_valid;
  logic        addr_err;
  logic        busy;
  logic        par_err;

  // Observed vector: {fetch_valid, fetch_data, data_valid, data_rdata, addr_err, par_err}
  logic [35:0] obs;
  assign obs = {fetch_valid, fetch_data, data_valid, data_rdata, addr_err, par_err};

  logic [35:0] xq[$];
  logic [15:0] model [DEPTH];
  logic [15:0] fd_hold, dd_hold;
  int          n_assert = 0;
  int          n_fail   = 0;

  dual_port_memory #(
    .DATA_W      (16),
    .ADDR_W      (16),
    .DEPTH       (DEPTH),
    .CLEAR_VALUE (16'h0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_en    (fetch_en),
    .fetch_addr  (fetch_addr),
    .fetch_data  (fetch_data),
    .fetch_valid (fetch_valid),
    .data_en     (data_en),
    .data_we     (data_we),
    .data_addr   (data_addr),
    .data_wdata  (data_wdata),
    .data_rdata  (data_rdata),
    .data_valid  (data_valid),
    .addr_err    (addr_err),
    .busy        (busy),
    .par_err     (par_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference state after a clear: every word holds the clear value, outputs held at 0.
  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model[i] = 16'h0000;
    fd_hold = 16'h0000;
    dd_hold = 16'h0000;
    xq.delete();
  endtask

  // Drive one request cycle from a negedge and push the expected observation for the next negedge.
  task automatic drive(input logic fe, input logic [15:0] fa, input logic de, input logic dwe,
                       input logic [15:0] da, input logic [15:0] dwd);
    logic dv, ae;
    fetch_en   = fe;
    fetch_addr = fa;
    data_en    = de;
    data_we    = dwe;
    data_addr  = da;
    data_wdata = dwd;
    dv = de && !dwe;
    if (fe) fd_hold = (fa < DEPTH) ? model[fa[7:0]] : 16'h0000;
    if (dv) dd_hold = (da < DEPTH) ? model[da[7:0]] : 16'h0000;
    ae = (fe && fa >= DEPTH) || (de && da >= DEPTH);
    xq.push_back({fe, fd_hold, dv, dd_hold, ae, 1'b0});
    if (de && dwe && da < DEPTH) model[da[7:0]] = dwd;
    @(negedge clk);
    fetch_en = 1'b0;
    data_en  = 1'b0;
    data_we  = 1'b0;
  endtask

  // Counts negedges with busy high starting at the reset-release negedge.
  task automatic count_busy(output int cnt);
    cnt = 0;
    while (busy === 1'b1 && cnt < 1000) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int cnt;
    logic [35:0] exp;
    rst = 1'b1;
    fetch_en = 0; fetch_addr = 0; data_en = 0; data_we = 0; data_addr = 0; data_wdata = 0;
    repeat (3) @(negedge clk);
    n_assert++;
    if (obs !== 36'h0) begin n_fail++; $display("FAIL reset_outputs: got %h want %h", obs, 36'h0); end
    n_assert++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b want 1", busy); end
    rst = 1'b0;
    model_clear();
    count_busy(cnt);
    n_assert++;
    if (cnt != DEPTH) begin n_fail++; $display("FAIL busy_cycles: got %0d want %0d", cnt, DEPTH); end
    drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    exp = xq.pop_front();
    n_assert++;
    if (obs !== exp) begin n_fail++; $display("FAIL idle_after_clear: got %h want %h", obs, exp); end
  endtask

  task automatic test_clear_values();
    logic [15:0] addrs [3];
    logic [35:0] exp;
    addrs[0] = 16'd0; addrs[1] = 16'd128; addrs[2] = 16'd255;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, addrs[i], 1'b0, 1'b0, 16'h0, 16'h0);
      exp = xq.pop_front();
      n_assert++;
      if (obs !== exp) begin n_fail++; $display("FAIL clear_fetch_%0d: got %h want %h", addrs[i], obs, exp); end
    end
  endtask

  task automatic test_write_read();
    logic [35:0] exp;
    drive(1'b0, 16'h0, 1'b1, 1'b1, 16'h0010, 16'hBEEF);
    exp = xq.pop_front();
    n_assert++;
    if (obs !== exp) begin n_fail++; $display("FAIL write_beef: got %h want %h", obs, exp); end
    drive(1'b1, 16'h0010, 1'b1, 1'b0, 16'h0010, 16'h0);
    exp = xq.pop_front();
    n_assert++;
    if (obs !== exp) begin n_fail++; $display("FAIL read_beef: got %h want %h", obs, exp); end
    drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    exp = xq.pop_front();
    n_assert++;
    if (obs !== exp) begin n_fail++; $display("FAIL hold_after_read: got %h want %h", obs, exp); end
  endtask

  task automatic test_collision();
    logic [35:0] exp;
    drive(1'b0, 16'h0, 1'b1, 1'b1, 16'd5, 16'hBEEF);
    exp = xq.pop_front();
    n_assert++;
    if (obs !== exp) begin n_fail++; $display("FAIL coll_setup: got %h want %h", obs, exp); end
    drive(1'b1, 16'd5, 1'b1, 1'b1, 16'd5, 16'h1234);
    exp = xq.pop_front();
    n_assert++;
    if (obs !== exp) begin n_fail++; $display("FAIL coll_read_first: got %h want %h", obs, exp); end
    drive(1'b1, 16'd5, 1'b0, 1'b0, 16'h0, 16'h0);
    exp = xq.pop_front();
    n_assert++;
    if (obs !== exp) begin n_fail++; $display("FAIL coll_new_word: got %h want %h", obs, exp); end
  endtask

  task automatic test_out_of_range();
    logic [35:0] exp;
    drive(1'b0, 16'h0, 1'b1, 1'b1, 16'h0100, 16'hAAAA);
    exp = xq.pop_front();
    n_assert++;
    if (obs !== exp) begin n_fail++; $display("FAIL oor_write: got %h want %h", obs, exp); end
    drive(1'b0, 16'h0, 1'b1, 1'b0, 16'h0100, 16'h0);
    exp = xq.pop_front();
    n_assert++;
    if (obs !== exp) begin n_fail++; $display("FAIL oor_read: got %h want %h", obs, exp); end
    drive(1'b1, 16'hFFFF, 1'b1, 1'b0, 16'h01FF, 16'h0);
    exp = xq.pop_front();
    n_assert++;
    if (obs !== exp) begin n_fail++; $display("FAIL oor_both: got %h want %h", obs, exp); end
    drive(1'b1, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0);
    exp = xq.pop_front();
    n_assert++;
    if (obs !== exp) begin n_fail++; $display("FAIL oor_no_alias: got %h want %h", obs, exp); end
    drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    exp = xq.pop_front();
    n_assert++;
    if (obs !== exp) begin n_fail++; $display("FAIL oor_err_drop: got %h want %h", obs, exp); end
  endtask

  task automatic test_parity();
    logic [35:0] exp;
`ifdef DUAL_PORT_MEMORY_PARITY_EN
    dut.mem[7][16] = ~dut.mem[7][16];
    drive(1'b1, 16'd7, 1'b0, 1'b0, 16'h0, 16'h0);
    exp = xq.pop_front();
    exp[0] = 1'b1;
    n_assert++;
    if (obs !== exp) begin n_fail++; $display("FAIL parity_fetch: got %h want %h", obs, exp); end
    drive(1'b0, 16'h0, 1'b1, 1'b0, 16'd7, 16'h0);
    exp = xq.pop_front();
    exp[0] = 1'b1;
    n_assert++;
    if (obs !== exp) begin n_fail++; $display("FAIL parity_data: got %h want %h", obs, exp); end
    drive(1'b0, 16'h0, 1'b1, 1'b1, 16'd7, 16'h00C3);
    exp = xq.pop_front();
    n_assert++;
    if (obs !== exp) begin n_fail++; $display("FAIL parity_repair: got %h want %h", obs, exp); end
    drive(1'b1, 16'd7, 1'b0, 1'b0, 16'h0, 16'h0);
    exp = xq.pop_front();
    n_assert++;
    if (obs !== exp) begin n_fail++; $display("FAIL parity_clean: got %h want %h", obs, exp); end
`else
    drive(1'b1, 16'd7, 1'b1, 1'b0, 16'd7, 16'h0);
    exp = xq.pop_front();
    n_assert++;
    if (obs !== exp) begin n_fail++; $display("FAIL parity_off_read: got %h want %h", obs, exp); end
    n_assert++;
    if (par_err !== 1'b0) begin n_fail++; $display("FAIL parity_off_flag: got %b want 0", par_err); end
`endif
  endtask

  function automatic logic [15:0] pick_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 7) return 16'($urandom_range(0, 7));
    if (r == 7) return 16'($urandom_range(0, 255));
    if (r == 8) return 16'h0100 + 16'($urandom_range(0, 255));
    return 16'hFFFF;
  endfunction

  task automatic test_back_to_back();
    logic [35:0] exp;
    for (int i = 0; i < 80; i++) begin
      drive(1'($urandom_range(0, 1)), pick_addr(), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), pick_addr(), 16'($urandom));
      exp = xq.pop_front();
      n_assert++;
      if (obs !== exp) begin n_fail++; $display("FAIL b2b_%0d: got %h want %h", i, obs, exp); end
    end
  endtask

  task automatic test_busy_reset();
    int cnt;
    logic [35:0] exp;
    rst = 1'b1;
    #1;
    n_assert++;
    if (obs !== 36'h0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL async_reset: got %h busy %b want 0 busy 1", obs, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    for (int i = 0; i < 100; i++) begin
      fetch_en = 1'b1; fetch_addr = pick_addr();
      data_en = 1'b1; data_we = 1'($urandom_range(0, 1)); data_addr = pick_addr(); data_wdata = 16'($urandom);
      @(negedge clk);
      n_assert++;
      if ({fetch_valid, data_valid, addr_err, busy} !== 4'b0001) begin
        n_fail++; $display("FAIL busy_ignore_%0d: got fv/dv/ae/busy %b want 0001", i,
                           {fetch_valid, data_valid, addr_err, busy});
      end
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    data_we = 1'b1; data_addr = 16'h0010; data_wdata = 16'h5555;
    count_busy(cnt);
    fetch_en = 1'b0; data_en = 1'b0; data_we = 1'b0;
    n_assert++;
    if (cnt != DEPTH) begin n_fail++; $display("FAIL busy_restart: got %0d want %0d", cnt, DEPTH); end
    n_assert++;
    if ({fetch_valid, data_valid, addr_err} !== 3'b000) begin
      n_fail++; $display("FAIL busy_last_edge: got %b want 000", {fetch_valid, data_valid, addr_err});
    end
    drive(1'b1, 16'h0010, 1'b1, 1'b0, 16'h0010, 16'h0);
    exp = xq.pop_front();
    n_assert++;
    if (obs !== exp) begin n_fail++; $display("FAIL busy_no_write: got %h want %h", obs, exp); end
  endtask

  initial begin
    test_reset();
    test_clear_values();
    test_write_read();
    test_collision();
    test_out_of_range();
    test_parity();
    test_back_to_back();
    test_busy_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
